// File: rtl/uart_sched_pkg.sv
// Shared types and defaults for the UART TX scheduler.
// UART_SCHED_RR_EN selects round-robin over fixed-priority arbitration.
package uart_sched_pkg;
  localparam int DATA_LEN_DEF = 8;
  localparam int N_REQ_DEF    = 2;
  localparam int N_REQ_MAX    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } drain_state_t;
endpackage

// File: rtl/uart_rr_arbiter.sv
// Picks one requesting producer per cycle; the search starts at a registered pointer.
// UART_SCHED_RR_EN defined: pointer moves past each winner. Undefined: pointer stays 0 (lowest index wins).
module uart_rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_enable,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_index
);
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptrNext;
  logic [IDX_W-1:0] winIdx;
  logic             found;
  logic [IDX_W:0]   cand;

  // Wrapping scan from ptr; cand is one bit wider so the wrap compare cannot overflow.
  always_comb begin
    winIdx = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (!found && i_req[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winIdx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (i_enable && found) o_grant[winIdx] = 1'b1;
  end

  assign o_index = winIdx;

`ifdef UART_SCHED_RR_EN
  always_comb begin
    ptrNext = ptr;
    if (i_enable && found)
      ptrNext = (winIdx == IDX_W'(N_REQ - 1)) ? '0 : winIdx + IDX_W'(1);
  end
`else
  assign ptrNext = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) ptr <= '0;
    else         ptr <= ptrNext;
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates byte producers onto a shared TX FIFO and drains it into uart_tx, one pop per frame.
// UART_SCHED_RR_EN (in uart_rr_arbiter) selects round-robin instead of fixed priority.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int N_REQ    = N_REQ_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*DATA_LEN-1:0] i_req_data,
  output logic [N_REQ-1:0]          o_grant,
  input  logic                      i_fifo_full,
  input  logic                      i_fifo_empty,
  input  logic [DATA_LEN-1:0]       i_fifo_rdata,
  output logic                      o_fifo_write,
  output logic [DATA_LEN-1:0]       o_fifo_wdata,
  output logic                      o_fifo_read,
  input  logic                      i_drain_en,
  output logic                      o_tx_start,
  output logic [DATA_LEN-1:0]       o_tx_data,
  input  logic                      i_tx_done,
  output logic                      o_busy,
  output drain_state_t              o_dbg_state
);
  localparam int IDX_W = $clog2(N_REQ);

  // Handshake: i_req[i] is valid and must hold with its byte stable until o_grant[i];
  // the grant pulse is the ready and the byte is written to the FIFO in that same cycle.
  logic [IDX_W-1:0] winIdx;

  uart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_req    (i_req),
    .i_enable (~i_fifo_full & ~i_reset),
    .o_grant  (o_grant),
    .o_index  (winIdx)
  );

  assign o_fifo_write = |o_grant;
  assign o_fifo_wdata = o_fifo_write ? i_req_data[int'(winIdx)*DATA_LEN +: DATA_LEN] : '0;

  drain_state_t        state;
  drain_state_t        stateNext;
  logic [DATA_LEN-1:0] txData;
  logic [DATA_LEN-1:0] txDataNext;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      txData <= '0;
    end else begin
      state  <= stateNext;
      txData <= txDataNext;
    end
  end

  // The pop and the latch of the head byte happen together, so o_tx_data is stable for the whole frame.
  always_comb begin
    stateNext   = state;
    txDataNext  = txData;
    o_fifo_read = 1'b0;
    o_tx_start  = 1'b0;
    case (state)
      IDLE: begin
        if (i_drain_en && !i_fifo_empty && !i_reset) begin
          o_fifo_read = 1'b1;
          txDataNext  = i_fifo_rdata;
          stateNext   = START;
        end
      end
      START: begin
        o_tx_start = 1'b1;
        stateNext  = BUSY;
      end
      BUSY: begin
        if (i_tx_done) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign o_tx_data   = txData;
  assign o_busy      = (state != IDLE);
  assign o_dbg_state = state;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler with a FIFO/uart_tx environment and a frame-level reference model.
module tb_uart_tx_scheduler;
  import uart_sched_pkg::*;

  localparam int DATA_LEN   = 8;
  localparam int N_REQ      = 2;
  localparam int FIFO_DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst = 1'b1;
  logic [N_REQ-1:0]          req = '0;
  logic [N_REQ*DATA_LEN-1:0] req_data = '0;
  logic [N_REQ-1:0]          grant;
  logic                      fifo_full = 1'b0;
  logic                      fifo_empty = 1'b1;
  logic [DATA_LEN-1:0]       fifo_rdata = '0;
  logic                      fifo_write;
  logic [DATA_LEN-1:0]       fifo_wdata;
  logic                      fifo_read;
  logic                      drain_en = 1'b0;
  logic                      tx_start;
  logic [DATA_LEN-1:0]       tx_data;
  logic                      tx_done = 1'b0;
  logic                      busy;
  drain_state_t              dbg_state;

  uart_tx_scheduler #(.DATA_LEN(DATA_LEN), .N_REQ(N_REQ)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req        (req),
    .i_req_data   (req_data),
    .o_grant      (grant),
    .i_fifo_full  (fifo_full),
    .i_fifo_empty (fifo_empty),
    .i_fifo_rdata (fifo_rdata),
    .o_fifo_write (fifo_write),
    .o_fifo_wdata (fifo_wdata),
    .o_fifo_read  (fifo_read),
    .i_drain_en   (drain_en),
    .o_tx_start   (tx_start),
    .o_tx_data    (tx_data),
    .i_tx_done    (tx_done),
    .o_busy       (busy),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- environment + reference model ----------------
  logic [DATA_LEN-1:0] fifo_q[$];   // environment FIFO, moved by the DUT strobes
  logic [DATA_LEN-1:0] exp_q[$];    // scoreboard: bytes the arbitration rules say were accepted
  int                  m_ptr = 0;   // next producer with first claim
  int                  m_stage = 0; // 0 no frame, 1 start due this cycle, 2 waiting for done
  logic [DATA_LEN-1:0] m_txdata = '0;
  int                  done_cnt = 0;
  bit                  spurious = 1'b0;
  int                  cyc = 0;
  int                  last_grant_cyc = 0;
  int                  last_start_cyc = 0;
  int                  start_count = 0;
  logic [DATA_LEN-1:0] last_start_data = '0;
  drain_state_t        st_map[3] = '{IDLE, START, BUSY};

  function automatic void refresh_fifo();
    fifo_full  = (fifo_q.size() == FIFO_DEPTH);
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? '0 : fifo_q[0];
  endfunction

  // One clock: check at negedge, advance model, then update environment after posedge.
  task automatic step();
    logic [N_REQ-1:0]    e_grant;
    logic [DATA_LEN-1:0] e_wdata;
    logic                e_rd;
    logic [N_REQ-1:0]    a_grant;
    logic                a_wr;
    logic                a_rd;
    logic [DATA_LEN-1:0] a_wdata;
    int                  w;
    @(negedge clk);
    cyc++;
    e_grant = '0;
    e_wdata = '0;
    w = -1;
    if (!rst && !fifo_full) begin
      for (int k = 0; k < N_REQ; k++) begin
        int c;
        c = (m_ptr + k) % N_REQ;
        if (w < 0 && req[c]) w = c;
      end
      if (w >= 0) begin
        e_grant[w] = 1'b1;
        e_wdata    = req_data[w*DATA_LEN +: DATA_LEN];
      end
    end
    e_rd = !rst && drain_en && (m_stage == 0) && !fifo_empty;

    check("grant",      32'(grant),      32'(e_grant));
    check("fifo_write", 32'(fifo_write), 32'(w >= 0));
    check("fifo_wdata", 32'(fifo_wdata), 32'(e_wdata));
    check("fifo_read",  32'(fifo_read),  32'(e_rd));
    check("tx_start",   32'(tx_start),   32'(m_stage == 1));
    check("busy",       32'(busy),       32'(m_stage != 0));
    check("tx_data",    32'(tx_data),    32'(m_txdata));
    check("state",      32'(dbg_state),  32'(st_map[m_stage]));
    check("pop_empty",  32'(fifo_read & fifo_empty), 32'(0));
    check("write_full", 32'(fifo_write & fifo_full), 32'(0));

    if (grant != '0) last_grant_cyc = cyc;
    if (tx_start) begin
      last_start_cyc  = cyc;
      last_start_data = tx_data;
      start_count++;
      done_cnt = $urandom_range(2, 5);
    end
    a_grant = grant;
    a_wr    = fifo_write;
    a_rd    = fifo_read;
    a_wdata = fifo_wdata;

    // model advance
    if (rst) begin
      m_stage  = 0;
      m_txdata = '0;
      m_ptr    = 0;
      exp_q.delete();
    end else begin
      if (e_rd) begin
        if (exp_q.size() > 0) m_txdata = exp_q.pop_front();
        m_stage = 1;
      end else if (m_stage == 1) begin
        m_stage = 2;
      end else if (m_stage == 2 && tx_done) begin
        m_stage = 0;
      end
      if (w >= 0) begin
        exp_q.push_back(e_wdata);
`ifdef UART_SCHED_RR_EN
        m_ptr = (w + 1) % N_REQ;
`endif
      end
    end

    @(posedge clk);
    #1;
    if (rst) begin
      fifo_q.delete();
    end else begin
      if (a_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (a_wr) fifo_q.push_back(a_wdata);
    end
    refresh_fifo();
    req = req & ~a_grant;
    tx_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) tx_done = 1'b1;
    end else if (spurious && m_stage != 2 && $urandom_range(0, 7) == 0) begin
      tx_done = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    drain_en = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic raise(input int idx, input logic [DATA_LEN-1:0] b);
    req[idx] = 1'b1;
    req_data[idx*DATA_LEN +: DATA_LEN] = b;
  endtask

  // ---------------- sequences ----------------
  initial begin
    int s0;
    int guard;

    // reset values
    do_reset();
    check("reset_busy",   32'(busy),      32'(0));
    check("reset_txdata", 32'(tx_data),   32'(0));
    check("reset_state",  32'(dbg_state), 32'(IDLE));

    // single byte into an empty FIFO: grant T, pop T+1, start T+2
    drain_en = 1'b1;
    raise(0, 8'hA5);
    for (int i = 0; i < 8; i++) step();
    check("latency",    32'(last_start_cyc - last_grant_cyc), 32'(2));
    check("first_byte", 32'(last_start_data), 32'(8'hA5));
    for (int i = 0; i < 8; i++) step();

    // both producers held high for four cycles with draining off; fills the FIFO
    do_reset();
    for (int i = 0; i < 4; i++) begin
      raise(0, 8'h11);
      raise(1, 8'h22);
      step();
    end
    check("fifo_filled", 32'(fifo_full), 32'(1));

    // full FIFO with producer 1 waiting: pop first, grant on the following cycle
    req = '0;
    raise(1, 8'h77);
    drain_en = 1'b1;
    for (int i = 0; i < 60; i++) step();

    // draining held off: three bytes wait, then go out in order
    do_reset();
    s0 = start_count;
    for (int i = 0; i < 3; i++) begin
      raise(0, 8'(8'h30 + i));
      step();
    end
    for (int i = 0; i < 6; i++) step();
    check("no_start_when_off", 32'(start_count - s0), 32'(0));
    drain_en = 1'b1;
    for (int i = 0; i < 40; i++) step();
    check("three_frames", 32'(start_count - s0), 32'(3));

    // reset in the middle of a frame, late tx_done must be ignored
    do_reset();
    drain_en = 1'b1;
    raise(0, 8'h5C);
    guard = 0;
    while (m_stage != 2 && guard < 50) begin
      step();
      guard++;
    end
    check("reach_busy", 32'(m_stage), 32'(2));
    done_cnt = 6;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy",   32'(busy),       32'(0));
    check("abort_txdata", 32'(tx_data),    32'(0));
    check("abort_start",  32'(tx_start),   32'(0));
    for (int i = 0; i < 10; i++) step();

    // randomized traffic with drain toggling and stray tx_done pulses
    spurious = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N_REQ; k++)
        if (!req[k] && $urandom_range(0, 2) == 0) raise(k, 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 15) == 0) drain_en = ~drain_en;
      step();
    end

    // drain everything that was accepted
    spurious = 1'b0;
    req = '0;
    drain_en = 1'b1;
    guard = 0;
    while ((exp_q.size() > 0 || m_stage != 0) && guard < 500) begin
      step();
      guard++;
    end
    check("drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
